mem_bus_arbiter: RTL

- Shares the single memory bus between two requesters: the I-cache (fetch misses, loads only) and the D-cache (loads and stores).
- Tracks which requester owns each outstanding memory tag and routes returning data to that owner.
- Discards I-side data whose request was made before a fetch flush, so stale instructions never reach the fetch stage.
- Sits between both caches and the memory model, below the fetch stage.

---
 rtl/mem_bus_arbiter_pkg.sv | 23 ++
 rtl/mem_bus_arbiter_if.sv | 38 +++
 rtl/mem_bus_arbiter_tag_table.sv | 41 ++++
 rtl/mem_bus_arbiter.sv | 69 ++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings, widths and tag-table types for the memory bus arbiter.
package mem_bus_arbiter_pkg;
  localparam int TAG_W        = 4;
  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 64;
  localparam int STARVE_LIMIT = 4;
  localparam int NUM_TAGS     = 1 << TAG_W;

  localparam logic [1:0] BUS_NONE  = 2'b00;
  localparam logic [1:0] BUS_LOAD  = 2'b01;
  localparam logic [1:0] BUS_STORE = 2'b10;

  typedef logic [TAG_W-1:0]  MEM_TAG_t;
  typedef logic [DATA_W-1:0] MEM_DATA_t;

  typedef enum logic {OWN_IC = 1'b0, OWN_DC = 1'b1} mem_owner_e;

  typedef struct packed {
    logic       busy;
    mem_owner_e owner;
    logic       dropped;
  } tag_entry_t;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Cache-side request/response and memory-side bus signals of the arbiter.
interface mem_bus_arbiter_if;
  import mem_bus_arbiter_pkg::*;

  logic              fetch_flush;
  logic              ic_req_valid;
  logic [ADDR_W-1:0] ic_req_addr;
  logic              ic_req_accepted;
  logic              ic_resp_valid;
  MEM_DATA_t         ic_resp_data;
  logic              dc_req_valid;
  logic [1:0]        dc_req_cmd;
  logic [ADDR_W-1:0] dc_req_addr;
  MEM_DATA_t         dc_req_data;
  logic              dc_req_accepted;
  logic              dc_resp_valid;
  MEM_DATA_t         dc_resp_data;
  logic [1:0]        proc2mem_command;
  logic [ADDR_W-1:0] proc2mem_addr;
  MEM_DATA_t         proc2mem_data;
  MEM_TAG_t          mem2proc_response;
  MEM_DATA_t         mem2proc_data;
  MEM_TAG_t          mem2proc_tag;

  // slave: the arbiter itself; master: caches + memory model around it
  modport slave (
    input  fetch_flush, ic_req_valid, ic_req_addr, dc_req_valid, dc_req_cmd,
           dc_req_addr, dc_req_data, mem2proc_response, mem2proc_data, mem2proc_tag,
    output ic_req_accepted, ic_resp_valid, ic_resp_data, dc_req_accepted,
           dc_resp_valid, dc_resp_data, proc2mem_command, proc2mem_addr, proc2mem_data
  );
  modport master (
    output fetch_flush, ic_req_valid, ic_req_addr, dc_req_valid, dc_req_cmd,
           dc_req_addr, dc_req_data, mem2proc_response, mem2proc_data, mem2proc_tag,
    input  ic_req_accepted, ic_resp_valid, ic_resp_data, dc_req_accepted,
           dc_resp_valid, dc_resp_data, proc2mem_command, proc2mem_addr, proc2mem_data
  );
endinterface

// File: rtl/mem_bus_arbiter_tag_table.sv
// Per-tag ownership table: allocate on accepted load, look up/clear on return,
// mark in-flight I-cache loads dropped on fetch flush.
module mem_tag_table
  import mem_bus_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       alloc_en_i,
  input  MEM_TAG_t   alloc_tag_i,
  input  mem_owner_e alloc_owner_i,
  input  logic       alloc_drop_i,
  input  MEM_TAG_t   lkup_tag_i,
  input  logic       flush_i,
  output logic       ic_hit_o,
  output logic       dc_hit_o
);
  tag_entry_t [NUM_TAGS-1:0] tbl_q, tbl_d;
  tag_entry_t                lk;
  logic                      lk_hit;

  always_comb begin
    lk       = tbl_q[lkup_tag_i];
    lk_hit   = (lkup_tag_i != '0) && lk.busy;
    ic_hit_o = lk_hit && (lk.owner == OWN_IC) && !lk.dropped;
    dc_hit_o = lk_hit && (lk.owner == OWN_DC);

    tbl_d = tbl_q;
    for (int i = 0; i < NUM_TAGS; i++)
      if (flush_i && tbl_q[i].busy && (tbl_q[i].owner == OWN_IC))
        tbl_d[i].dropped = 1'b1;
    if (lk_hit) tbl_d[lkup_tag_i] = '0;
    // allocation is applied last so it beats a same-tag clear
    if (alloc_en_i)
      tbl_d[alloc_tag_i] = '{busy: 1'b1, owner: alloc_owner_i, dropped: alloc_drop_i};
  end

  always_ff @(posedge clock) begin
    if (reset) tbl_q <= '0;
    else       tbl_q <= tbl_d;
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter: D-cache priority with I-cache anti-starvation,
// tag ownership tracking and flush-aware response routing.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  mem_bus_arbiter_if.slave  bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_q, starve_d;
  logic          ic_prio, ic_gnt, dc_gnt, rsp_ok, ic_acc, dc_acc;
  logic          alloc_en, ic_hit, dc_hit;

  always_comb begin
    ic_prio = bus.ic_req_valid && (starve_q >= SW'(STARVE_LIMIT));
    ic_gnt  = bus.ic_req_valid && (!bus.dc_req_valid || ic_prio);
    dc_gnt  = bus.dc_req_valid && !ic_gnt;
    rsp_ok  = (bus.mem2proc_response != '0) && !reset;
    ic_acc  = ic_gnt && rsp_ok;
    dc_acc  = dc_gnt && rsp_ok;
    // stores get a tag from memory but never a data return
    alloc_en = ic_acc || (dc_acc && (bus.dc_req_cmd == BUS_LOAD));

    starve_d = starve_q;
    if (!bus.ic_req_valid || ic_acc)    starve_d = '0;
    else if (starve_q < SW'(STARVE_LIMIT)) starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end

  mem_tag_table u_tags (
    .clock        (clock),
    .reset        (reset),
    .alloc_en_i   (alloc_en),
    .alloc_tag_i  (bus.mem2proc_response),
    .alloc_owner_i(ic_acc ? OWN_IC : OWN_DC),
    .alloc_drop_i (ic_acc && bus.fetch_flush),
    .lkup_tag_i   (bus.mem2proc_tag),
    .flush_i      (bus.fetch_flush),
    .ic_hit_o     (ic_hit),
    .dc_hit_o     (dc_hit)
  );

  always_comb begin
    bus.proc2mem_command = BUS_NONE;
    bus.proc2mem_addr    = '0;
    bus.proc2mem_data    = '0;
    if (!reset && ic_gnt) begin
      bus.proc2mem_command = BUS_LOAD;
      bus.proc2mem_addr    = bus.ic_req_addr;
    end else if (!reset && dc_gnt) begin
      bus.proc2mem_command = bus.dc_req_cmd;
      bus.proc2mem_addr    = bus.dc_req_addr;
      bus.proc2mem_data    = bus.dc_req_data;
    end
    bus.ic_req_accepted = ic_acc;
    bus.dc_req_accepted = dc_acc;
    // an I-side return coinciding with a flush is already stale
    bus.ic_resp_valid   = !reset && ic_hit && !bus.fetch_flush;
    bus.dc_resp_valid   = !reset && dc_hit;
    bus.ic_resp_data    = reset ? '0 : bus.mem2proc_data;
    bus.dc_resp_data    = reset ? '0 : bus.mem2proc_data;
  end
endmodule
